// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the SPI host and the Levenshtein engine shared access to one external memory port.
// One cycle from request to mem_req; a BUSY watchdog returns an err pulse if mem_ack never comes.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  h_req,
  input  logic                  h_we,
  input  logic [ADDR_WIDTH-1:0] h_addr,
  input  logic [7:0]            h_wdata,
  output logic                  h_ack,
  output logic                  h_err,
  output logic [7:0]            h_rdata,
  input  logic                  e_req,
  input  logic                  e_we,
  input  logic [ADDR_WIDTH-1:0] e_addr,
  input  logic [7:0]            e_wdata,
  output logic                  e_ack,
  output logic                  e_err,
  output logic [7:0]            e_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_rdata,
  output logic                  busy
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_last_e, w_last_e_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt, w_cnt_inc;
  logic                  r_mem_req, w_mem_req_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [7:0]            r_mem_wdata, w_mem_wdata_nxt;
  logic                  r_h_ack, w_h_ack_nxt, r_h_err, w_h_err_nxt;
  logic                  r_e_ack, w_e_ack_nxt, r_e_err, w_e_err_nxt;
  logic [7:0]            r_h_rdata, w_h_rdata_nxt, r_e_rdata, w_e_rdata_nxt;
  logic                  w_h_elig, w_e_elig, w_pick_e;

  // A requester whose completion pulse is showing this cycle sits out, which lets the other side in.
  assign w_h_elig  = h_req & ~r_h_ack & ~r_h_err;
  assign w_e_elig  = e_req & ~r_e_ack & ~r_e_err;
  assign w_pick_e  = w_e_elig & (~w_h_elig | ~r_last_e);
  assign w_cnt_inc = (r_cnt >= TO) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_nxt     = r_state;
    w_last_e_nxt    = r_last_e;
    w_cnt_nxt       = r_cnt;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_h_ack_nxt     = 1'b0;
    w_h_err_nxt     = 1'b0;
    w_e_ack_nxt     = 1'b0;
    w_e_err_nxt     = 1'b0;
    w_h_rdata_nxt   = r_h_rdata;
    w_e_rdata_nxt   = r_e_rdata;
    case (r_state)
      S_IDLE: begin
        if (w_h_elig || w_e_elig) begin
          w_state_nxt     = S_BUSY;
          w_mem_req_nxt   = 1'b1;
          w_last_e_nxt    = w_pick_e;
          w_cnt_nxt       = '0;
          w_mem_we_nxt    = w_pick_e ? e_we    : h_we;
          w_mem_addr_nxt  = w_pick_e ? e_addr  : h_addr;
          w_mem_wdata_nxt = w_pick_e ? e_wdata : h_wdata;
        end
      end
      S_BUSY: begin
        // mem_ack takes priority over a watchdog expiry in the same cycle.
        if (mem_ack) begin
          w_state_nxt   = S_IDLE;
          w_mem_req_nxt = 1'b0;
          if (r_last_e) begin
            w_e_ack_nxt   = 1'b1;
            w_e_rdata_nxt = mem_rdata;
          end else begin
            w_h_ack_nxt   = 1'b1;
            w_h_rdata_nxt = mem_rdata;
          end
        end else if (w_cnt_inc >= TO) begin
          w_state_nxt   = S_IDLE;
          w_mem_req_nxt = 1'b0;
          w_cnt_nxt     = w_cnt_inc;
          w_e_err_nxt   = r_last_e;
          w_h_err_nxt   = ~r_last_e;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last_e    <= 1'b1;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_h_ack     <= 1'b0;
      r_h_err     <= 1'b0;
      r_e_ack     <= 1'b0;
      r_e_err     <= 1'b0;
      r_h_rdata   <= '0;
      r_e_rdata   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_e    <= w_last_e_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_h_ack     <= w_h_ack_nxt;
      r_h_err     <= w_h_err_nxt;
      r_e_ack     <= w_e_ack_nxt;
      r_e_err     <= w_e_err_nxt;
      r_h_rdata   <= w_h_rdata_nxt;
      r_e_rdata   <= w_e_rdata_nxt;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign h_ack     = r_h_ack;
  assign h_err     = r_h_err;
  assign h_rdata   = r_h_rdata;
  assign e_ack     = r_e_ack;
  assign e_err     = r_e_err;
  assign e_rdata   = r_e_rdata;
  assign busy      = (r_state == S_BUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed host/engine traffic against a simple memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        h_req, h_we, e_req, e_we;
  logic [15:0] h_addr, e_addr;
  logic [7:0]  h_wdata, e_wdata;
  logic        h_ack, h_err, e_ack, e_err;
  logic [7:0]  h_rdata, e_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        busy;

  typedef struct { bit who; bit err; logic [7:0] rd; } rsp_t;
  typedef struct { logic we; logic [15:0] addr; logic [7:0] wd; } cmd_t;
  rsp_t rsp_q[$];
  cmd_t cmd_q[$];

  int checks = 0;
  int errors = 0;
  bit ack_en = 1'b1;
  int ack_lat = 2;
  logic [7:0] rdval = 8'h00;
  int mcnt = 0;
  int last_len = 0;
  bit gap_en = 1'b0;
  bit mon_prev = 1'b0;
  int low_run = 0;
  int rises = 0;
  logic [24:0] cap = '0;

  mem_arbiter #(.ADDR_WIDTH(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_err(h_err), .h_rdata(h_rdata),
    .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_ack(e_ack), .e_err(e_err), .e_rdata(e_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic we, input logic [15:0] a, input logic [7:0] d);
    cmd_t c;
    c.we = we; c.addr = a; c.wd = d;
    cmd_q.push_back(c);
  endtask

  task automatic push_rsp(input bit who, input bit err, input logic [7:0] rd);
    rsp_t r;
    r.who = who; r.err = err; r.rd = rd;
    rsp_q.push_back(r);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem"}, {7'd0, mem_req, mem_we, mem_addr, mem_wdata}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_host"}, {22'd0, h_ack, h_err, h_rdata}, 32'd0);
    chk({tag, "_eng"}, {22'd0, e_ack, e_err, e_rdata}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
  endtask

  // Waits for n completions (ack or err); drops each request on its completion, or all at the end.
  task automatic wait_done(input int n, input bit drop_each);
    int k = 0;
    int t = 0;
    while (k < n && t < 200) begin
      @(negedge clk);
      t++;
      if (h_ack || h_err) begin k++; if (drop_each) h_req = 1'b0; end
      if (e_ack || e_err) begin k++; if (drop_each) e_req = 1'b0; end
    end
    h_req = 1'b0;
    e_req = 1'b0;
    if (k < n) chk("wait_completion", k, n);
  endtask

  // Memory model: acks ack_lat cycles after mem_req rises, returning rdval and then incrementing it.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        mcnt++;
        if (ack_en && mcnt == ack_lat) begin
          mem_ack = 1'b1;
          mem_rdata = rdval;
          rdval = rdval + 8'd1;
        end
      end else begin
        if (mcnt != 0) last_len = mcnt;
        mcnt = 0;
      end
    end
  end

  // Monitor: pops expected commands on mem_req rise and expected responses on ack/err pulses.
  initial begin
    rsp_t r;
    cmd_t c;
    forever begin
      @(negedge clk);
      if (h_ack || h_err || e_ack || e_err) begin
        chk("rsp_exclusive", {29'd0, h_ack & h_err, e_ack & e_err, (h_ack | h_err) & (e_ack | e_err)}, 32'd0);
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got h_ack=%b h_err=%b e_ack=%b e_err=%b expected none", h_ack, h_err, e_ack, e_err);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_who", {31'd0, e_ack | e_err}, {31'd0, r.who});
          chk("rsp_is_err", {31'd0, h_err | e_err}, {31'd0, r.err});
          chk("rsp_rdata", {24'd0, (e_ack | e_err) ? e_rdata : h_rdata}, {24'd0, r.rd});
        end
      end
      if (mem_req && !mon_prev) begin
        if (cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd: got addr %h expected none", mem_addr);
        end else begin
          c = cmd_q.pop_front();
          chk("cmd", {7'd0, mem_we, mem_addr, mem_wdata}, {7'd0, c.we, c.addr, c.wd});
        end
        cap = {mem_we, mem_addr, mem_wdata};
        if (gap_en) begin
          if (rises > 0) chk("req_gap", low_run, 1);
          rises++;
        end
        low_run = 0;
      end else if (mem_req) begin
        chk("cmd_stable", {7'd0, mem_we, mem_addr, mem_wdata}, {7'd0, cap});
      end else begin
        low_run++;
      end
      if (!gap_en) rises = 0;
      mon_prev = mem_req;
    end
  end

  initial begin
    rst_n = 1'b0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    repeat (3) @(negedge clk);
    chk_zero("por");
    rst_n = 1'b1;

    // Host-only read, mem_ack two cycles after mem_req.
    rdval = 8'hA5; ack_lat = 2;
    push_cmd(1'b0, 16'h1234, 8'h00);
    push_rsp(1'b0, 1'b0, 8'hA5);
    h_we = 1'b0; h_addr = 16'h1234; h_wdata = 8'h00; h_req = 1'b1;
    @(negedge clk);
    chk("t1_req_latency", {31'd0, mem_req}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_done(1, 1'b1);
    @(negedge clk);
    chk("t1_ack_one_cycle", {31'd0, h_ack}, 32'd0);
    chk("t1_rdata_hold", {24'd0, h_rdata}, 32'h A5);

    // Tie after reset, both held: host, engine, host, engine.
    do_reset();
    rdval = 8'h11; gap_en = 1'b1;
    push_cmd(1'b0, 16'h0100, 8'h00); push_cmd(1'b1, 16'h0200, 8'h77);
    push_cmd(1'b0, 16'h0100, 8'h00); push_cmd(1'b1, 16'h0200, 8'h77);
    push_rsp(1'b0, 1'b0, 8'h11); push_rsp(1'b1, 1'b0, 8'h12);
    push_rsp(1'b0, 1'b0, 8'h13); push_rsp(1'b1, 1'b0, 8'h14);
    h_we = 1'b0; h_addr = 16'h0100; h_wdata = 8'h00;
    e_we = 1'b1; e_addr = 16'h0200; e_wdata = 8'h77;
    h_req = 1'b1; e_req = 1'b1;
    wait_done(4, 1'b0);
    gap_en = 1'b0;

    // Engine write with host arriving and engine inputs changing mid-transaction.
    @(negedge clk);
    ack_lat = 3; gap_en = 1'b1;
    push_cmd(1'b1, 16'h0010, 8'h3C); push_cmd(1'b0, 16'h0555, 8'h00);
    push_rsp(1'b1, 1'b0, 8'h15); push_rsp(1'b0, 1'b0, 8'h16);
    e_we = 1'b1; e_addr = 16'h0010; e_wdata = 8'h3C; e_req = 1'b1;
    @(negedge clk);
    h_we = 1'b0; h_addr = 16'h0555; h_wdata = 8'h00; h_req = 1'b1;
    e_we = 1'b0; e_addr = 16'hFFFF; e_wdata = 8'h00;
    wait_done(2, 1'b1);
    gap_en = 1'b0;

    // Engine timeout: no mem_ack, err after 4 BUSY cycles, rdata kept.
    @(negedge clk);
    ack_en = 1'b0;
    push_cmd(1'b0, 16'h0020, 8'h00);
    push_rsp(1'b1, 1'b1, 8'h15);
    e_we = 1'b0; e_addr = 16'h0020; e_wdata = 8'h00; e_req = 1'b1;
    wait_done(1, 1'b1);
    @(negedge clk);
    chk("t4_err_one_cycle", {31'd0, e_err}, 32'd0);
    chk("t4_busy_len", last_len, 4);
    chk("t4_rdata_kept", {24'd0, e_rdata}, 32'h15);
    ack_en = 1'b1;

    // mem_ack on the timeout cycle: ack only.
    ack_lat = 4;
    push_cmd(1'b0, 16'h0030, 8'h00);
    push_rsp(1'b0, 1'b0, 8'h17);
    h_we = 1'b0; h_addr = 16'h0030; h_req = 1'b1;
    wait_done(1, 1'b1);
    @(negedge clk);
    chk("t5_busy_len", last_len, 4);
    chk("t5_no_err", {30'd0, h_err, e_err}, 32'd0);

    // Reset while BUSY, then a tie must go to the host first.
    ack_en = 1'b0;
    push_cmd(1'b0, 16'h0040, 8'h00);
    h_addr = 16'h0040; h_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_busy_before_rst", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    h_req = 1'b0;
    @(negedge clk);
    ack_en = 1'b1; ack_lat = 1; gap_en = 1'b1;
    push_cmd(1'b0, 16'h0050, 8'h00); push_cmd(1'b1, 16'h0060, 8'h99);
    push_rsp(1'b0, 1'b0, 8'h18); push_rsp(1'b1, 1'b0, 8'h19);
    h_we = 1'b0; h_addr = 16'h0050; h_req = 1'b1;
    e_we = 1'b1; e_addr = 16'h0060; e_wdata = 8'h99; e_req = 1'b1;
    rst_n = 1'b1;
    wait_done(2, 1'b1);
    gap_en = 1'b0;

    repeat (3) @(negedge clk);
    chk("rsp_q_drained", rsp_q.size(), 0);
    chk("cmd_q_drained", cmd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, external memory address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum BUSY cycles to wait for mem_ack.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports h_req/h_we  input  1/1  host (SPI bridge) request level and write flag.
REQ-006 SHALL have ports h_addr/h_wdata  input  ADDR_WIDTH/8  host address and write data.
REQ-007 SHALL have ports h_ack/h_err  output  1/1  host completion and timeout pulses.
REQ-008 SHALL have port h_rdata  output  8  host read data, valid during the h_ack pulse.
REQ-009 SHALL have ports e_req, e_we, e_addr, e_wdata, e_ack, e_err, e_rdata; same directions and widths as the h_* ports, for the Levenshtein engine.
REQ-010 SHALL have ports mem_req/mem_we  output  1/1  request and write flag to the external memory (PMOD) controller.
REQ-011 SHALL have ports mem_addr/mem_wdata  output  ADDR_WIDTH/8  registered command to memory.
REQ-012 SHALL have ports mem_ack/mem_rdata  input  1/8  memory completion and read data.
REQ-013 SHALL have port busy  output  1  high while in BUSY state.

Function
REQ-014 SHALL implement two states: IDLE and BUSY.
REQ-015 In IDLE, a requester SHALL be eligible when its req is high and its own ack/err is not high in that cycle.
REQ-016 If exactly one requester is eligible in IDLE, it SHALL be granted at the next edge.
REQ-017 If both are eligible, the requester not recorded in last_grant SHALL be granted (round-robin).
REQ-018 On grant, the arbiter SHALL capture we, addr and wdata into mem_we/mem_addr/mem_wdata, set mem_req=1, busy=1 and last_grant=winner, and enter BUSY (one-cycle latency from req to mem_req).
REQ-019 In BUSY, mem_req and the mem_* command SHALL stay stable until mem_ack is sampled high, regardless of changes on either requester's inputs.
REQ-020 On the edge where mem_ack=1 is sampled, the arbiter SHALL clear mem_req and busy, pulse the granted requester's ack for exactly one cycle, load its rdata from mem_rdata (also on writes), and return to IDLE.
REQ-021 Every rdata output SHALL hold its last value outside ack pulses.
REQ-022 A timeout counter SHALL clear on grant and increment each BUSY cycle; when it reaches TIMEOUT without mem_ack, the arbiter SHALL clear mem_req, pulse the granted requester's err for one cycle, leave its rdata unchanged, and return to IDLE.
REQ-023 If mem_ack and the timeout occur in the same cycle, ack SHALL win and no err SHALL pulse.
REQ-024 mem_ack while in IDLE SHALL be ignored.
REQ-025 mem_req SHALL be low for at least one cycle between transactions.
REQ-026 The ungranted requester SHALL be held (no ack/err) until granted; its inputs SHALL not be sampled before grant.
REQ-027 ack and err SHALL never both be high, and at most one requester SHALL see ack or err per cycle.
REQ-028 The timeout counter SHALL be wide enough for TIMEOUT and SHALL saturate.

Reset
REQ-029 While rst_n=0, the following SHALL be 0, including mid-transaction: mem_req, mem_we, mem_addr, mem_wdata, busy, h_ack, h_err, h_rdata, e_ack, e_err, e_rdata, and the counter. State SHALL be IDLE and last_grant SHALL be engine, so the host wins the first tie.
REQ-030 After rst_n rises, the first grant SHALL occur no earlier than the first rising clk edge with rst_n high.

Verification
REQ-031 Host-only read of addr 0x1234 with mem_ack two cycles after mem_req and mem_rdata=0xA5 -> mem_req one cycle after h_req; h_ack pulses 1 cycle with h_rdata=0xA5.
REQ-032 h_req and e_req asserted together after reset and held -> grant order host, engine, host, engine; mem_req low 1 cycle between grants.
REQ-033 Engine write of 0x3C to 0x0010, with h_req rising during BUSY -> mem_* command unchanged until mem_ack; host granted in the IDLE cycle after e_ack.
REQ-034 TIMEOUT=4, mem_ack never asserted -> mem_req drops after 4 BUSY cycles; e_err pulses once; e_rdata unchanged.
REQ-035 mem_ack coincident with the timeout cycle -> ack pulse only, no err.
REQ-036 rst_n pulled low while BUSY -> all outputs 0 immediately; after release, a host/engine tie grants host first.
